// File: rtl/board_dot_scanner_if.sv
// Scan bus for board_dot_scanner: enable/board/cursor toward the scanner, dot matrix drive back.
interface board_dot_scanner_if #(
    parameter int unsigned GRID = 3
) ();
    localparam int unsigned DIM = 4 * GRID - 1;

    logic                   en;
    logic [2*GRID*GRID-1:0] board;
    logic [3:0]             cursor;
    logic [DIM-1:0]         dot_row;
    logic [DIM-1:0]         dot_col;
    logic                   frame_start;

    modport master (
        output en, board, cursor,
        input  dot_row, dot_col, frame_start
    );

    modport slave (
        input  en, board, cursor,
        output dot_row, dot_col, frame_start
    );
endinterface

// File: rtl/board_dot_scanner.sv
// Row-multiplexed dot-matrix scanner for a GRID x GRID board of 3x3 glyphs with 1-dot gaps.
// Define CURSOR_BLINK_EN to blank the cursor cell on alternate blink phases.
module board_dot_scanner #(
    parameter int unsigned GRID         = 3,
    parameter int unsigned ROW_DIV      = 12500,
    parameter int unsigned BLINK_FRAMES = 16
) (
    input logic                clk,
    input logic                rst,
    board_dot_scanner_if.slave scan
);
    localparam int unsigned DIM = 4 * GRID - 1;
    localparam int unsigned BW  = 2 * GRID * GRID;
    localparam int unsigned CW  = (ROW_DIV > 1) ? $clog2(ROW_DIV) : 1;
    localparam int unsigned RW  = $clog2(DIM);

    logic [CW-1:0]  div_q, div_d;
    logic           idle_q, idle_d;
    logic [RW-1:0]  row_idx_q, row_idx_d;
    logic [DIM-1:0] dot_row_q, dot_row_d;
    logic [DIM-1:0] dot_col_q, dot_col_d;
    logic           frame_start_q, frame_start_d;
    logic [BW-1:0]  snap_q, snap_d;

    logic           tick;
    logic [RW-1:0]  next_row;
    logic           start_frame;

    logic           hide_live_en, hide_snap_en;
    logic [3:0]     hide_live_idx, hide_snap_idx;

    // One glyph row for every cell on a dot row; gap rows and gap columns stay dark.
    function automatic logic [DIM-1:0] render_row(logic [RW-1:0] row, logic [BW-1:0] b,
                                                  logic hide_en, logic [3:0] hide_idx);
        logic [DIM-1:0] col;
        logic [1:0]     code;
        logic [2:0]     glyph;
        int unsigned    cr;
        int unsigned    k;
        col = '0;
        cr  = 32'(row[RW-1:2]);
        if (row[1:0] != 2'd3) begin
            for (int unsigned cc = 0; cc < GRID; cc++) begin
                k    = cr * GRID + cc;
                code = b[2*k +: 2];
                if (hide_en && (32'(hide_idx) == k)) begin
                    code = 2'b00;
                end
                case (code)
                    2'b00:   glyph = 3'b000;
                    2'b01:   glyph = (row[1:0] == 2'd1) ? 3'b010 : 3'b101;
                    2'b10:   glyph = (row[1:0] == 2'd1) ? 3'b101 : 3'b111;
                    default: glyph = 3'b111;
                endcase
                col[4*cc +: 3] = glyph;
            end
        end
        return col;
    endfunction

    assign tick        = scan.en && (div_q == CW'(ROW_DIV - 1));
    assign next_row    = (idle_q || (row_idx_q == RW'(DIM - 1))) ? '0 : row_idx_q + 1'b1;
    assign start_frame = tick && (next_row == '0);

    always_comb begin
        div_d         = div_q;
        idle_d        = idle_q;
        row_idx_d     = row_idx_q;
        dot_row_d     = dot_row_q;
        dot_col_d     = dot_col_q;
        frame_start_d = 1'b0;
        snap_d        = snap_q;
        if (!scan.en) begin
            div_d     = '0;
            idle_d    = 1'b1;
            dot_row_d = '0;
            dot_col_d = '0;
        end else begin
            div_d = tick ? '0 : div_q + 1'b1;
            if (tick) begin
                idle_d    = 1'b0;
                row_idx_d = next_row;
                dot_row_d = DIM'(1) << next_row;
                if (start_frame) begin
                    // Row 0 bypasses the snapshot so the new frame shows the live board at once.
                    snap_d        = scan.board;
                    frame_start_d = 1'b1;
                    dot_col_d     = render_row(next_row, scan.board, hide_live_en, hide_live_idx);
                end else begin
                    dot_col_d     = render_row(next_row, snap_q, hide_snap_en, hide_snap_idx);
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_q         <= '0;
            idle_q        <= 1'b1;
            row_idx_q     <= '0;
            dot_row_q     <= '0;
            dot_col_q     <= '0;
            frame_start_q <= 1'b0;
            snap_q        <= '0;
        end else begin
            div_q         <= div_d;
            idle_q        <= idle_d;
            row_idx_q     <= row_idx_d;
            dot_row_q     <= dot_row_d;
            dot_col_q     <= dot_col_d;
            frame_start_q <= frame_start_d;
            snap_q        <= snap_d;
        end
    end

`ifdef CURSOR_BLINK_EN
    localparam int unsigned FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [FW-1:0] frame_cnt_q, frame_cnt_d;
    logic          blink_q, blink_d;
    logic          snap_blink_q, snap_blink_d;
    logic [3:0]    snap_cursor_q, snap_cursor_d;

    // Phase is latched with the board at frame start, so a frame renders with one phase throughout.
    always_comb begin
        frame_cnt_d   = frame_cnt_q;
        blink_d       = blink_q;
        snap_blink_d  = snap_blink_q;
        snap_cursor_d = snap_cursor_q;
        if (frame_start_q) begin
            if (frame_cnt_q == FW'(BLINK_FRAMES - 1)) begin
                frame_cnt_d = '0;
                blink_d     = ~blink_q;
            end else begin
                frame_cnt_d = frame_cnt_q + 1'b1;
            end
        end
        if (start_frame) begin
            snap_blink_d  = blink_q;
            snap_cursor_d = scan.cursor;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q   <= '0;
            blink_q       <= 1'b0;
            snap_blink_q  <= 1'b0;
            snap_cursor_q <= '0;
        end else begin
            frame_cnt_q   <= frame_cnt_d;
            blink_q       <= blink_d;
            snap_blink_q  <= snap_blink_d;
            snap_cursor_q <= snap_cursor_d;
        end
    end

    assign hide_live_en  = blink_q;
    assign hide_live_idx = scan.cursor;
    assign hide_snap_en  = snap_blink_q;
    assign hide_snap_idx = snap_cursor_q;
`else
    logic unused_cfg;
    assign unused_cfg    = ^{scan.cursor, BLINK_FRAMES[0]};
    assign hide_live_en  = 1'b0;
    assign hide_live_idx = '0;
    assign hide_snap_en  = 1'b0;
    assign hide_snap_idx = '0;
`endif

    assign scan.dot_row     = dot_row_q;
    assign scan.dot_col     = dot_col_q;
    assign scan.frame_start = frame_start_q;

endmodule

// File: tb/tb_board_dot_scanner.sv
// Directed bench for board_dot_scanner (GRID=3, ROW_DIV=4, BLINK_FRAMES=2) with a row scoreboard.
module tb_board_dot_scanner;
    localparam int unsigned GRID = 3;
`ifdef CURSOR_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    typedef struct packed {
        logic [10:0] row;
        logic [10:0] col;
        logic        fs;
    } exp_t;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   cyc_cnt;
    int   last_evt;
    int   last_fs;
    int   prev_fs;
    exp_t sb[$];

    board_dot_scanner_if #(.GRID(GRID)) scan ();

    board_dot_scanner #(
        .GRID        (GRID),
        .ROW_DIV     (4),
        .BLINK_FRAMES(2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .scan(scan)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial cyc_cnt = 0;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Reference: walk every dot column, map it to its cell and glyph offset.
    function automatic logic [10:0] model_col(int r, logic [17:0] b, bit hide, int cur);
        logic [10:0] v;
        v = '0;
        for (int c = 0; c < 11; c++) begin
            int         ro;
            int         co;
            int         k;
            logic [1:0] g;
            logic [8:0] pat;
            ro = r % 4;
            co = c % 4;
            if (ro != 3 && co != 3) begin
                k = (r / 4) * 3 + (c / 4);
                g = b[2*k +: 2];
                if (hide && k == cur) g = 2'b00;
                case (g)
                    2'd0:    pat = 9'b000_000_000;
                    2'd1:    pat = 9'b101_010_101;
                    2'd2:    pat = 9'b111_101_111;
                    default: pat = 9'b111_111_111;
                endcase
                v[c] = pat[8 - (ro * 3 + co)];
            end
        end
        return v;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic push_rows(input int first, input int last, input logic [17:0] b,
                             input bit hide, input int cur);
        for (int r = first; r <= last; r++) begin
            exp_t e;
            e.row = 11'(1) << r;
            e.col = model_col(r, b, hide, cur);
            e.fs  = (r == 0);
            sb.push_back(e);
        end
    endtask

    task automatic push_solid(input int first, input int last);
        for (int r = first; r <= last; r++) begin
            exp_t e;
            e.row = 11'(1) << r;
            e.col = (r % 4 == 3) ? 11'h000 : 11'h777;
            e.fs  = (r == 0);
            sb.push_back(e);
        end
    endtask

    // Wait for dot_row to move, bounded; report the edge count since the previous event.
    task automatic wait_row(output exp_t got, output int gap, output bit ok);
        logic [10:0] prev;
        prev = scan.dot_row;
        ok   = 1'b0;
        got  = '0;
        gap  = 0;
        for (int i = 0; i < 40 && !ok; i++) begin
            @(negedge clk);
            if (scan.dot_row !== prev) ok = 1'b1;
        end
        if (ok) begin
            got.row  = scan.dot_row;
            got.col  = scan.dot_col;
            got.fs   = scan.frame_start;
            gap      = cyc_cnt - last_evt;
            last_evt = cyc_cnt;
            if (got.fs === 1'b1) begin
                prev_fs = last_fs;
                last_fs = cyc_cnt;
            end
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) begin
            exp_t got;
            exp_t e;
            int   gap;
            bit   ok;
            wait_row(got, gap, ok);
            checks++;
            assert (ok) else begin
                failures++;
                $error("FAIL row_timeout observed=none expected=row_change");
            end
            if (sb.size() > 0) begin
                e = sb.pop_front();
                check("row_sel", 32'(got.row), 32'(e.row));
                check("row_col", 32'(got.col), 32'(e.col));
                check("row_fs", 32'(got.fs), 32'(e.fs));
                check("row_gap", 32'(gap), 32'd4);
            end
        end
    endtask

    initial begin
        checks      = 0;
        failures    = 0;
        last_evt    = 0;
        last_fs     = 0;
        prev_fs     = 0;
        rst         = 1'b1;
        scan.en     = 1'b0;
        scan.board  = '0;
        scan.cursor = 4'hF;
        repeat (3) @(negedge clk);
        check("rst_dot_row", 32'(scan.dot_row), 32'h0);
        check("rst_dot_col", 32'(scan.dot_col), 32'h0);
        check("rst_frame_start", 32'(scan.frame_start), 32'h0);

        // First frame: X in the top-left cell, latency and frame period.
        scan.board = 18'h00001;
        scan.en    = 1'b1;
        rst        = 1'b0;
        last_evt   = cyc_cnt;
        push_rows(0, 10, 18'h00001, 1'b0, 0);
        push_rows(0, 0, 18'h00001, 1'b0, 0);
        drain(1);
        @(negedge clk);
        check("fs_one_cycle", 32'(scan.frame_start), 32'h0);
        drain(11);
        check("fs_period", 32'(last_fs - prev_fs), 32'd44);

        // Board changes mid-frame are held off until the next row 0.
        scan.board = 18'h3FFFF;
        push_rows(1, 10, 18'h00001, 1'b0, 0);
        drain(10);
        push_solid(0, 2);
        drain(3);
        scan.board = 18'h00000;
        push_solid(3, 10);
        drain(8);
        push_rows(0, 6, 18'h00000, 1'b0, 0);
        drain(7);

        // Drop enable at row 6, then restart.
        scan.en = 1'b0;
        @(negedge clk);
        check("en_off_row", 32'(scan.dot_row), 32'h0);
        check("en_off_col", 32'(scan.dot_col), 32'h0);
        repeat (3) @(negedge clk);
        check("en_off_hold", 32'(scan.dot_row), 32'h0);
        scan.board = 18'h2D8E4;
        scan.en    = 1'b1;
        last_evt   = cyc_cnt;
        push_rows(0, 4, 18'h2D8E4, 1'b0, 0);
        drain(5);

        // Asynchronous reset at row 4, between clock edges.
        rst = 1'b1;
        #1;
        check("arst_row", 32'(scan.dot_row), 32'h0);
        check("arst_col", 32'(scan.dot_col), 32'h0);
        check("arst_fs", 32'(scan.frame_start), 32'h0);
        scan.board  = 18'h3FFFF;
        scan.cursor = 4'd4;
        repeat (2) @(negedge clk);
        rst      = 1'b0;
        last_evt = cyc_cnt;

        // Blink phase runs in pairs of frames from reset; cursor 9 is off the board.
        for (int f = 0; f < 7; f++) begin
            bit hide;
            int cur;
            cur  = (f < 4) ? 4 : 9;
            hide = BLINK && (((f / 2) % 2) == 1);
            push_rows(0, 10, 18'h3FFFF, hide, cur);
            drain(11);
            if (f == 3) scan.cursor = 4'd9;
        end

        checks++;
        assert (sb.size() == 0) else begin
            failures++;
            $error("FAIL sb_leftover observed=%0d expected=0", sb.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/board_dot_scanner.md
BOARD_DOT_SCANNER -- requirements
Module: board_dot_scanner

Interface
REQ-001 Parameter GRID, default 3: cells per board side; legal range 2..4.
REQ-002 Parameter ROW_DIV, default 12500: clk cycles per row tick; minimum 2.
REQ-003 Parameter BLINK_FRAMES, default 16: frames per cursor blink half-period; minimum 1.
REQ-004 Derived DIM = 4*GRID-1: dot rows and dot columns.
REQ-005 clk  in  1  system clock; all state on rising edge.
REQ-006 rst  in  1  reset, asynchronous, active-high.
REQ-007 en  in  1  scan enable.
REQ-008 board  in  2*GRID*GRID  cell k in bits [2k+1:2k]; k = cellrow*GRID + cellcol; k=0 is top-left.
REQ-009 cursor  in  4  selected cell index; values >= GRID*GRID mean no cursor.
REQ-010 dot_row  out  DIM  one-hot row select, active-high; bit 0 is the top row.
REQ-011 dot_col  out  DIM  column data for the selected row; bit 0 is the leftmost column.
REQ-012 frame_start  out  1  one-cycle pulse on the tick that starts row 0.

Function
REQ-013 Divider counts 0..ROW_DIV-1 while en=1 and asserts tick in the cycle it holds ROW_DIV-1, then wraps to 0.
REQ-014 On tick, the next row is 0 if the block is idle or row_idx=DIM-1; otherwise it is row_idx+1.
REQ-015 On tick, dot_row, dot_col and row_idx are registered together; output latency is 1 clk after tick.
REQ-016 When the next row is 0, the snapshot register captures board in the same edge, row 0 data comes directly from board, and frame_start pulses for one cycle.
REQ-017 Rows 1..DIM-1 use only the snapshot; board changes mid-frame have no visible effect until the next frame.
REQ-018 Dot (r,c) belongs to cell (r/4, c/4) with glyph offset (r%4, c%4); offset 3 on either axis is a gap and is always 0.
REQ-019 Glyph code 00 is blank; 01 (X) is rows 101/010/101; 10 (O) is 111/101/111; 11 (solid) is 111/111/111; glyph bit j maps to dot_col bit 4*cellcol+j.
REQ-020 Frame counter increments on each frame_start; at BLINK_FRAMES-1 it wraps to 0 and toggles blink phase.
REQ-021 When en=0, the divider clears, the block becomes idle, dot_row=0 and dot_col=0 on the next edge, and the snapshot and blink state hold.
REQ-022 The first tick after en rises starts a new frame at row 0.

Reset
REQ-023 Reset sets divider=0, row_idx=0, idle, dot_row=0, dot_col=0, frame_start=0, snapshot=0, frame counter=0, blink phase=0.
REQ-024 Reset mid-frame aborts the scan immediately; the first tick after release starts at row 0 with frame_start=1.

Configuration
REQ-025 When macro CURSOR_BLINK_EN is defined and blink phase=1, the cursor cell renders blank; otherwise the cell renders normally.
REQ-026 When CURSOR_BLINK_EN is undefined, the cursor input is ignored, the frame counter and blink logic are absent, and all cells render per REQ-019.

Verification (GRID=3, ROW_DIV=4, BLINK_FRAMES=2)
REQ-027 Release reset, en=1, board=18'h00001: cycle after first tick gives dot_row=11'h001, dot_col=11'h005, frame_start=1 for exactly one cycle.
REQ-028 Hold en=1: dot_row walks 0x001..0x400 once every 4 cycles, returns to 0x001, and frame_start pulses every 44 cycles.
REQ-029 Set board to all 2'b11, then change it to 0 during row 2: rows 2..10 keep the old data; the next frame's row 0 shows 0.
REQ-030 Board all 2'b11: rows 3 and 7 give dot_col=0; row 5 gives dot_col=11'h777.
REQ-031 With CURSOR_BLINK_EN, cursor=4, board all 2'b11: row 5 gives 11'h777 in frames 0-1 and 11'h707 in frames 2-3; cursor=9 gives 11'h777 always.
REQ-032 Drop en at row 6: dot_row=0 next cycle; raise en: after 4 cycles row 0 shows with frame_start=1; rst asserted at row 4 clears the outputs asynchronously.
